// File: rtl/instr_enc_32_pkg.sv
// Local types for the instruction encoder / program loader.
package instr_enc_32_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } enc_state_t;

endpackage

// File: rtl/opcodes_pkg.sv
// Shared opcode set and format rules for the 32-bit core (decoder and encoder).
package opcodes_pkg;

    localparam int unsigned OPCODES_WIDTH = 6;

    typedef enum logic [OPCODES_WIDTH-1:0] {
        NOP_OP   = 6'd0,
        ADD_OP   = 6'd1,
        SUB_OP   = 6'd2,
        AND_OP   = 6'd3,
        OR_OP    = 6'd4,
        XOR_OP   = 6'd5,
        SLL_OP   = 6'd6,
        SRL_OP   = 6'd7,
        LOAD_OP  = 6'd8,
        STORE_OP = 6'd9,
        JMP_OP   = 6'd10
    } opcode_t;

    // Memory ops carry an immediate in place of the third register select
    function automatic logic is_mem_op(input logic [OPCODES_WIDTH-1:0] op);
        return (op == LOAD_OP) || (op == STORE_OP);
    endfunction

    // True only for codes that are members of opcode_t
    function automatic logic is_legal_op(input logic [OPCODES_WIDTH-1:0] op);
        case (op)
            NOP_OP, ADD_OP, SUB_OP, AND_OP, OR_OP, XOR_OP,
            SLL_OP, SRL_OP, LOAD_OP, STORE_OP, JMP_OP: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack_32.sv
// Combinational field-to-word packer with illegal-opcode flag; usable as a golden encoder.
module instr_pack_32
    import opcodes_pkg::*;
#(
    parameter int unsigned NUM_REG   = 32,
    parameter int unsigned REG_WIDTH = 32,
    localparam int unsigned REG_SELECT = $clog2(NUM_REG),
    localparam int unsigned IMM_W      = REG_WIDTH - OPCODES_WIDTH - 2*REG_SELECT,
    localparam int unsigned PAD_W      = REG_WIDTH - OPCODES_WIDTH - 3*REG_SELECT
) (
    input  logic [OPCODES_WIDTH-1:0] opcode,
    input  logic [REG_SELECT-1:0]    sel_a,
    input  logic [REG_SELECT-1:0]    sel_b,
    input  logic [REG_SELECT-1:0]    sel_c,
    input  logic [IMM_W-1:0]         imm,
    output logic [REG_WIDTH-1:0]     word_c,
    output logic                     illegal_c
);

    // Pick I- or R-format; illegal opcodes encode as an all-zero word
    always_comb begin
        word_c    = '0;
        illegal_c = 1'b0;
        if (!is_legal_op(opcode)) begin
            illegal_c = 1'b1;
        end else if (is_mem_op(opcode)) begin
            word_c = {opcode, sel_a, sel_b, imm};
        end else begin
            word_c = {opcode, sel_a, sel_b, sel_c, {PAD_W{1'b0}}};
        end
    end

endmodule

// File: rtl/instr_enc_32.sv
// Sequential instruction encoder: accepts field beats and writes packed words to consecutive addresses.
module instr_enc_32
    import opcodes_pkg::*;
    import instr_enc_32_pkg::*;
#(
    parameter int unsigned NUM_REG   = 32,
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned MEM_DEPTH = 256,
    localparam int unsigned REG_SELECT = $clog2(NUM_REG),
    localparam int unsigned ADDR_W     = $clog2(MEM_DEPTH),
    localparam int unsigned CNT_W      = ADDR_W + 1,
    localparam int unsigned IMM_W      = REG_WIDTH - OPCODES_WIDTH - 2*REG_SELECT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [ADDR_W-1:0]        i_base,
    input  logic [CNT_W-1:0]         i_len,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [OPCODES_WIDTH-1:0] i_opcode,
    input  logic [REG_SELECT-1:0]    i_sel_a,
    input  logic [REG_SELECT-1:0]    i_sel_b,
    input  logic [REG_SELECT-1:0]    i_sel_c,
    input  logic [IMM_W-1:0]         i_imm,
    output logic                     o_mem_we,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [REG_WIDTH-1:0]     o_mem_wdata,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    enc_state_t           state;
    logic [ADDR_W-1:0]    base;
    logic [CNT_W-1:0]     len;
    logic [CNT_W-1:0]     idx;
    logic [CNT_W-1:0]     idx_nxt;
    logic [ADDR_W-1:0]    wr_addr;
    logic [REG_WIDTH-1:0] word;
    logic                 illegal;
    logic                 accept;

    instr_pack_32 #(
        .NUM_REG   (NUM_REG),
        .REG_WIDTH (REG_WIDTH)
    ) u_pack (
        .opcode    (i_opcode),
        .sel_a     (i_sel_a),
        .sel_b     (i_sel_b),
        .sel_c     (i_sel_c),
        .imm       (i_imm),
        .word_c    (word),
        .illegal_c (illegal)
    );

    // Handshake and address arithmetic; address wraps naturally modulo MEM_DEPTH
    assign accept  = i_valid && o_ready;
    assign idx_nxt = CNT_W'(idx + CNT_W'(1));
    assign wr_addr = ADDR_W'(base + idx[ADDR_W-1:0]);

    // Run control FSM plus the one-deep registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            base        <= '0;
            len         <= '0;
            idx         <= '0;
            o_ready     <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            o_done   <= 1'b0;

            if (accept) begin
                o_mem_we    <= 1'b1;
                o_mem_addr  <= wr_addr;
                o_mem_wdata <= word;
                if (illegal) begin
                    o_err <= 1'b1;
                end
            end

            unique case (state)
                ST_IDLE: begin
                    o_busy <= 1'b0;
                    if (i_start) begin
                        base  <= i_base;
                        len   <= i_len;
                        idx   <= '0;
                        o_err <= 1'b0;
                        if (i_len == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            state   <= ST_LOAD;
                            o_ready <= 1'b1;
                            o_busy  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // Busy stays high through the cycle that carries the last write
                    o_busy <= 1'b1;
                    if (accept) begin
                        idx <= idx_nxt;
                        if (idx_nxt == len) begin
                            state   <= ST_IDLE;
                            o_ready <= 1'b0;
                            o_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_enc_32.sv
// Directed, table-driven bench for instr_enc_32.
module tb_instr_enc_32;
    import opcodes_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [7:0]  i_base;
    logic [8:0]  i_len;
    logic        i_valid;
    logic        o_ready;
    logic [5:0]  i_opcode;
    logic [4:0]  i_sel_a;
    logic [4:0]  i_sel_b;
    logic [4:0]  i_sel_c;
    logic [15:0] i_imm;
    logic        o_mem_we;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  c;
        logic [15:0] imm;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    instr_enc_32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base      (i_base),
        .i_len       (i_len),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_opcode    (i_opcode),
        .i_sel_a     (i_sel_a),
        .i_sel_b     (i_sel_b),
        .i_sel_c     (i_sel_c),
        .i_imm       (i_imm),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] base, input logic [8:0] len);
        i_start = 1'b1;
        i_base  = base;
        i_len   = len;
        tick();
        i_start = 1'b0;
    endtask

    task automatic set_beat(input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [15:0] imm);
        i_valid  = 1'b1;
        i_opcode = op;
        i_sel_a  = a;
        i_sel_b  = b;
        i_sel_c  = c;
        i_imm    = imm;
    endtask

    task automatic check_write(input string name, input logic [7:0] addr, input logic [31:0] data,
                               input logic done);
        check({name, ".we"},   32'(o_mem_we),   32'd1);
        check({name, ".addr"}, 32'(o_mem_addr), 32'(addr));
        check({name, ".data"}, o_mem_wdata,     data);
        check({name, ".done"}, 32'(o_done),     32'(done));
        check({name, ".busy"}, 32'(o_busy),     32'd1);
    endtask

    task automatic check_reset_outs(input string name);
        check({name, ".ready"}, 32'(o_ready),    32'd0);
        check({name, ".we"},    32'(o_mem_we),   32'd0);
        check({name, ".addr"},  32'(o_mem_addr), 32'd0);
        check({name, ".data"},  o_mem_wdata,     32'd0);
        check({name, ".busy"},  32'(o_busy),     32'd0);
        check({name, ".done"},  32'(o_done),     32'd0);
        check({name, ".err"},   32'(o_err),      32'd0);
    endtask

    initial begin
        // Hand-encoded words: {op[5:0], a[4:0], b[4:0], c[4:0], 11'b0} or {op, a, b, imm[15:0]}
        vecs[0] = '{6'd1,  5'd5,  5'd5,  5'd2,  16'h0000, 32'h04A5_1000};
        vecs[1] = '{6'd2,  5'd6,  5'd5,  5'd3,  16'h0000, {6'd2, 5'd6, 5'd5, 5'd3, 11'd0}};
        vecs[2] = '{6'd8,  5'd1,  5'd2,  5'd7,  16'hFFFF, {6'd8, 5'd1, 5'd2, 16'hFFFF}};
        vecs[3] = '{6'd9,  5'd31, 5'd0,  5'd3,  16'h1234, {6'd9, 5'd31, 5'd0, 16'h1234}};
        vecs[4] = '{6'd5,  5'd31, 5'd31, 5'd31, 16'hFFFF, {6'd5, 5'd31, 5'd31, 5'd31, 11'd0}};
        vecs[5] = '{6'd0,  5'd0,  5'd0,  5'd0,  16'hABCD, 32'h0000_0000};
        vecs[6] = '{6'd10, 5'd3,  5'd4,  5'd5,  16'h0001, {6'd10, 5'd3, 5'd4, 5'd5, 11'd0}};

        rst_n = 1'b0; i_start = 1'b0; i_base = '0; i_len = '0; i_valid = 1'b0;
        i_opcode = '0; i_sel_a = '0; i_sel_b = '0; i_sel_c = '0; i_imm = '0;
        #3;
        check_reset_outs("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Two-beat run from address 0, then the full table as one gap-free run
        start_run(8'd0, 9'd2);
        check("run2.busy_after_start", 32'(o_busy), 32'd1);
        check("run2.ready", 32'(o_ready), 32'd1);
        set_beat(ADD_OP, 5'd5, 5'd5, 5'd2, 16'h0);
        tick();
        check_write("run2.w0", 8'd0, 32'h04A5_1000, 1'b0);
        set_beat(SUB_OP, 5'd6, 5'd5, 5'd3, 16'h0);
        tick();
        i_valid = 1'b0;
        check_write("run2.w1", 8'd1, {6'd2, 5'd6, 5'd5, 5'd3, 11'd0}, 1'b1);
        check("run2.dec_a", 32'(o_mem_wdata[25:21]), 32'd6);
        check("run2.dec_b", 32'(o_mem_wdata[20:16]), 32'd5);
        check("run2.dec_c", 32'(o_mem_wdata[15:11]), 32'd3);
        check("run2.ready_end", 32'(o_ready), 32'd0);
        tick();
        check("run2.idle_we", 32'(o_mem_we), 32'd0);
        check("run2.idle_busy", 32'(o_busy), 32'd0);
        check("run2.idle_done", 32'(o_done), 32'd0);
        check("run2.hold_addr", 32'(o_mem_addr), 32'd1);

        start_run(8'd16, 9'(NV));
        for (int k = 0; k < NV; k++) begin
            set_beat(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].imm);
            tick();
            check_write($sformatf("tab%0d", k), 8'(16 + k), vecs[k].word, k == NV - 1);
            check($sformatf("tab%0d.err", k), 32'(o_err), 32'd0);
        end
        i_valid = 1'b0;
        tick();
        check("tab.idle_we", 32'(o_mem_we), 32'd0);

        // Wrap from the last address with valid toggling every other cycle
        start_run(8'd255, 9'd3);
        for (int k = 0; k < 3; k++) begin
            set_beat(ADD_OP, 5'(k), 5'd1, 5'd2, 16'h0);
            tick();
            i_valid = 1'b0;
            check_write($sformatf("wrap%0d", k), 8'(255 + k), {6'd1, 5'(k), 5'd1, 5'd2, 11'd0}, k == 2);
            tick();
            check($sformatf("wrap%0d.gap_we", k), 32'(o_mem_we), 32'd0);
            check($sformatf("wrap%0d.gap_done", k), 32'(o_done), 32'd0);
            check($sformatf("wrap%0d.gap_busy", k), 32'(o_busy), 32'(k != 2));
        end

        // Zero-length run: no writes, done one cycle after start
        start_run(8'd40, 9'd0);
        check("len0.done", 32'(o_done), 32'd1);
        check("len0.busy", 32'(o_busy), 32'd0);
        check("len0.ready", 32'(o_ready), 32'd0);
        check("len0.we", 32'(o_mem_we), 32'd0);
        tick();
        check("len0.done_pulse", 32'(o_done), 32'd0);

        // Illegal opcode in the middle of a three-beat run
        start_run(8'd100, 9'd3);
        set_beat(ADD_OP, 5'd1, 5'd2, 5'd3, 16'h0);
        tick();
        check("ill.w0.err", 32'(o_err), 32'd0);
        set_beat(6'h3F, 5'd9, 5'd9, 5'd9, 16'hFFFF);
        tick();
        check_write("ill.w1", 8'd101, 32'h0, 1'b0);
        check("ill.w1.err", 32'(o_err), 32'd1);
        set_beat(SUB_OP, 5'd4, 5'd5, 5'd6, 16'h0);
        tick();
        i_valid = 1'b0;
        check_write("ill.w2", 8'd102, {6'd2, 5'd4, 5'd5, 5'd6, 11'd0}, 1'b1);
        check("ill.w2.err", 32'(o_err), 32'd1);
        tick();
        check("ill.idle.err", 32'(o_err), 32'd1);
        start_run(8'd0, 9'd0);
        check("ill.cleared", 32'(o_err), 32'd0);

        // Reset after one of four beats aborts the run
        start_run(8'd50, 9'd4);
        set_beat(ADD_OP, 5'd7, 5'd7, 5'd7, 16'h0);
        tick();
        check_write("rst.w0", 8'd50, {6'd1, 5'd7, 5'd7, 5'd7, 11'd0}, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outs("rst.async");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rst.after%0d.we", k), 32'(o_mem_we), 32'd0);
            check($sformatf("rst.after%0d.done", k), 32'(o_done), 32'd0);
        end
        i_valid = 1'b0;
        start_run(8'd10, 9'd2);
        set_beat(OR_OP, 5'd1, 5'd1, 5'd1, 16'h0);
        tick();
        check_write("fresh.w0", 8'd10, {6'd4, 5'd1, 5'd1, 5'd1, 11'd0}, 1'b0);
        set_beat(LOAD_OP, 5'd2, 5'd3, 5'd4, 16'h00FF);
        tick();
        i_valid = 1'b0;
        check_write("fresh.w1", 8'd11, {6'd8, 5'd2, 5'd3, 16'h00FF}, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_enc_32.md
# instr_enc_32

Sequential instruction encoder and program loader for the 32-bit core. It accepts decoded instruction fields (opcode, three register selects, immediate) over a valid/ready handshake. It packs them into the exact 32-bit word format consumed by `opd_32`, and writes the words to consecutive instruction-memory addresses. It sits between the test/boot program source and the instruction memory, so any field set it encodes decodes back to identical fields.

## Interface
- `NUM_REG`, 32, register count; `REG_SELECT = $clog2(NUM_REG)`
- `REG_WIDTH`, 32, instruction/word width
- `MEM_DEPTH`, 256, instruction-memory words; `ADDR_W = $clog2(MEM_DEPTH)`
- `IMM_W` (derived), `REG_WIDTH - OPCODES_WIDTH - 2*REG_SELECT`, immediate field width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `i_start`  in  1  begin a load run (sampled only in IDLE)
- `i_base`  in  ADDR_W  first write address
- `i_len`  in  ADDR_W+1  number of instructions in the run (0..MEM_DEPTH)
- `i_valid`  in  1  field beat valid
- `o_ready`  out  1  encoder accepts a beat this cycle
- `i_opcode`  in  OPCODES_WIDTH  opcode (`opcodes_pkg` type)
- `i_sel_a`, `i_sel_b`, `i_sel_c`  in  REG_SELECT each  register selects
- `i_imm`  in  IMM_W  immediate (load/store only)
- `o_mem_we`  out  1  memory write strobe
- `o_mem_addr`  out  ADDR_W  write address
- `o_mem_wdata`  out  REG_WIDTH  encoded word
- `o_busy`  out  1  run in progress
- `o_done`  out  1  one-cycle pulse: run complete
- `o_err`  out  1  sticky: an illegal opcode was seen in the current run

## Operation
- The FSM has two states, IDLE and LOAD, plus a one-deep output register (word, address, valid).
- IDLE: `o_ready=0`. On `i_start`, the block latches `i_base` and `i_len`, clears the index and `o_err`, and moves to LOAD. With `i_len==0` it stays IDLE and pulses `o_done` the next cycle.
- LOAD: `o_ready=1` until `i_len` beats have been accepted. A beat is accepted when `i_valid && o_ready`.
- R-format (every opcode except load/store) is `{opcode, sel_a, sel_b, sel_c, zeros}`, with zeros filling to REG_WIDTH.
- I-format (load/store opcodes) is `{opcode, sel_a, sel_b, imm}`; `sel_c` is ignored.
- Address is `i_base + index`, modulo MEM_DEPTH. The address wraps from MEM_DEPTH-1 to 0 without error.
- Illegal opcode (not a member of the package opcode enum): the word is written as all zeros and `o_err` sets. `o_err` stays set until the next accepted `i_start`.
- `i_start` during LOAD is ignored.
- `o_busy=1` from the cycle after start until the cycle the last word is written, inclusive.

## Timing
- Reset: state IDLE, index 0. All outputs are 0: `o_ready`, `o_mem_we`, `o_mem_addr`, `o_mem_wdata`, `o_busy`, `o_done`, `o_err`.
- Beat accepted at edge t → `o_mem_we=1` with address and data during cycle t+1. Latency is one cycle, and a gap-free stream gives one write per cycle.
- No beat accepted → `o_mem_we=0` the following cycle. Address and data hold their last values.
- Last beat accepted at t: in cycle t+1, `o_mem_we=1` for the last word, `o_done=1`, and `o_busy=1`. The state is IDLE from t+1, with `o_ready=0`.
- `i_len==MEM_DEPTH` writes every address exactly once, starting at `i_base`.
- Reset mid-run aborts the run: no further writes, and no `o_done`.

## Structure
- `opcodes_pkg` (shared) holds `OPCODES_WIDTH`, the opcode enum and the load/store opcode constants. It also gains an `is_mem_op()` function so the decoder and encoder share one format rule.
- Sub-module `instr_pack_32`: purely combinational field-to-word packing plus the illegal-opcode flag. It is reusable by benches as a golden encoder.
- The FSM, counter and output register live in `instr_enc_32`.

## Test plan
- Reset, then base=0 and len=2. Beats `{ADD_OP,5,5,2}` and `{SUB_OP,6,5,3}` → writes at address 0: `{ADD_OP,5'd5,5'd5,5'd2,0}`; at address 1: `{SUB_OP,5'd6,5'd5,5'd3,0}`. `o_done` is set in the second write cycle, and `opd_32` fed the words returns the same selects.
- Load opcode with sel_a=1, sel_b=2, imm=all-ones and sel_c=7 → word `{LOAD_OP,5'd1,5'd2,imm}`; sel_c is absent.
- base=MEM_DEPTH-1, len=3, with `i_valid` toggling every other cycle → addresses MEM_DEPTH-1, 0, 1. There are no writes in idle-gap cycles, and `o_done` follows only the third write.
- len=0 → no writes, and `o_done` pulses one cycle after start.
- Illegal opcode as the 2nd of 3 beats → the 2nd word is 0 and `o_err` is set through done. The next `i_start` clears it.
- Assert `rst_n=0` after 1 of 4 beats → outputs 0 asynchronously. There are no further writes and no `o_done`, and a fresh run afterwards works normally.
